// File: rtl/hist_pkg.sv
// Shared constants and FSM encoding for the histogram accumulator.
package hist_pkg;

    localparam int ADDR_W   = 8;
    localparam int CNT_W    = 24;
    localparam int DROP_W   = 16;
    localparam int NUM_BINS = 1 << ADDR_W;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_INC_RD   = 3'd1,
        ST_INC_WAIT = 3'd2,
        ST_INC_WR   = 3'd3,
        ST_HRD_RD   = 3'd4,
        ST_HRD_WAIT = 3'd5,
        ST_CLEAR    = 3'd6
    } state_e;

endpackage

// File: rtl/hist_ram.sv
// Single-port histogram RAM with a registered read port (one clock of read latency).
module hist_ram #(
    parameter int ADDR_W = hist_pkg::ADDR_W,
    parameter int CNT_W  = hist_pkg::CNT_W
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [CNT_W-1:0]  wdata,
    output logic [CNT_W-1:0]  rdata
);

    logic [CNT_W-1:0] mem [1 << ADDR_W];
    logic [CNT_W-1:0] rdata_q;

    // Contents are deliberately not reset; the owner clears them by sweeping writes.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata_q <= mem[addr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/histogram_accumulator.sv
// 256-bin histogram: read-modify-write increment per Memory_add rise, host read and clear-all.
// HIST_SATURATE_EN: when defined, a full bin holds at all-ones instead of wrapping to zero.
module histogram_accumulator #(
    parameter int ADDR_W = hist_pkg::ADDR_W,
    parameter int CNT_W  = hist_pkg::CNT_W,
    parameter int DROP_W = hist_pkg::DROP_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] Addr,
    input  logic              Memory_add,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [CNT_W-1:0]  rd_data,
    output logic              rd_valid,
    input  logic              clr_req,
    output logic              busy,
    output logic [DROP_W-1:0] drop_count
);
    import hist_pkg::*;

    state_e            state_q, state_d;
    logic              mem_add_q, mem_add_d;
    logic              slot_full_q, slot_full_d;
    logic [ADDR_W-1:0] slot_addr_q, slot_addr_d;
    logic              rd_pend_q, rd_pend_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic              clr_pend_q, clr_pend_d;
    logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
    logic [CNT_W-1:0]  rd_data_q, rd_data_d;
    logic              rd_valid_q, rd_valid_d;
    logic              busy_q, busy_d;
    logic [DROP_W-1:0] drop_q, drop_d;

    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [CNT_W-1:0]  ram_wdata;
    logic [CNT_W-1:0]  ram_rdata;
    logic              evt;
    logic              evt_accept;

    hist_ram #(
        .ADDR_W (ADDR_W),
        .CNT_W  (CNT_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    always_comb begin
        state_d     = state_q;
        mem_add_d   = Memory_add;
        slot_full_d = slot_full_q;
        slot_addr_d = slot_addr_q;
        rd_pend_d   = rd_pend_q;
        rd_addr_d   = rd_addr_q;
        clr_pend_d  = clr_pend_q;
        clr_addr_d  = clr_addr_q;
        rd_data_d   = rd_data_q;
        rd_valid_d  = 1'b0;
        drop_d      = drop_q;
        ram_we      = 1'b0;
        ram_addr    = slot_addr_q;
        ram_wdata   = '0;

        // The slot frees in INC_WR, so an event landing in that very cycle refills it.
        evt        = Memory_add & ~mem_add_q;
        evt_accept = evt && (state_q != ST_CLEAR)
                         && (!slot_full_q || state_q == ST_INC_WR);

        if (rd_req) begin
            rd_pend_d = 1'b1;
            rd_addr_d = rd_addr;
        end
        if (clr_req) begin
            clr_pend_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (clr_req || clr_pend_q) begin
                    state_d    = ST_CLEAR;
                    clr_pend_d = 1'b0;
                    clr_addr_d = '0;
                end else if (slot_full_q) begin
                    state_d = ST_INC_RD;
                end else if (rd_pend_q) begin
                    state_d   = ST_HRD_RD;
                    rd_pend_d = 1'b0;
                end
            end
            ST_INC_RD: begin
                state_d = ST_INC_WAIT;
            end
            ST_INC_WAIT: begin
                state_d = ST_INC_WR;
            end
            ST_INC_WR: begin
                ram_wdata   = ram_rdata + CNT_W'(1);
`ifdef HIST_SATURATE_EN
                ram_we      = ~&ram_rdata;
`else
                ram_we      = 1'b1;
`endif
                slot_full_d = 1'b0;
                state_d     = ST_IDLE;
            end
            ST_HRD_RD: begin
                ram_addr = rd_addr_q;
                state_d  = ST_HRD_WAIT;
            end
            ST_HRD_WAIT: begin
                ram_addr   = rd_addr_q;
                rd_data_d  = ram_rdata;
                rd_valid_d = 1'b1;
                state_d    = ST_IDLE;
            end
            ST_CLEAR: begin
                ram_we     = 1'b1;
                ram_addr   = clr_addr_q;
                clr_addr_d = clr_addr_q + ADDR_W'(1);
                if (&clr_addr_q) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (evt_accept) begin
            slot_full_d = 1'b1;
            slot_addr_d = Addr;
        end else if (evt && (drop_q != {DROP_W{1'b1}})) begin
            drop_d = drop_q + DROP_W'(1);
        end

        busy_d = (state_d == ST_CLEAR) || (state_d == ST_INC_RD) || (state_d == ST_INC_WAIT)
                 || (state_d == ST_INC_WR) || slot_full_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            mem_add_q   <= 1'b0;
            slot_full_q <= 1'b0;
            slot_addr_q <= '0;
            rd_pend_q   <= 1'b0;
            rd_addr_q   <= '0;
            clr_pend_q  <= 1'b0;
            clr_addr_q  <= '0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
            busy_q      <= 1'b0;
            drop_q      <= '0;
        end else begin
            state_q     <= state_d;
            mem_add_q   <= mem_add_d;
            slot_full_q <= slot_full_d;
            slot_addr_q <= slot_addr_d;
            rd_pend_q   <= rd_pend_d;
            rd_addr_q   <= rd_addr_d;
            clr_pend_q  <= clr_pend_d;
            clr_addr_q  <= clr_addr_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
            busy_q      <= busy_d;
            drop_q      <= drop_d;
        end
    end

    assign rd_data    = rd_data_q;
    assign rd_valid   = rd_valid_q;
    assign busy       = busy_q;
    assign drop_count = drop_q;

endmodule
